// File: rtl/swm_tx_arbiter.sv
// swm_tx_arbiter: packet-level round-robin arbiter that shares one SerialLite3
// TX burst interface between NUM_SRC Avalon-ST 32-bit sources.
//
// Ports:
//   clk_in_clk, reset_in_rst         clock, async active-low reset
//   avalonst_sink_*                  NUM_SRC Avalon-ST sinks; source i data at [32i+31:32i]
//   data_tx[255:0]                   granted word in [31:0], upper bits zero
//   valid_tx, start_of_burst_tx,
//   end_of_burst_tx                  SerialLite3 burst framing
//   sync_tx[7:0]                     granted source index for far-end demux
//   ready_tx                         SerialLite3 back-pressure
//   drop_count[15:0]                 saturating count of orphan beats discarded in IDLE
//
// A grant is taken in IDLE (no beat moves that cycle), then the granted source
// streams straight through in BUSY until its EOP beat transfers. Packets longer
// than MAX_BURST beats are cut into several bursts without dropping the grant.

// Per-source handshake qualification.
module swm_tx_lane (
  input  logic rst_n,
  input  logic idle,
  input  logic granted,
  input  logic ready_tx,
  input  logic valid,
  input  logic sop,
  output logic cand,
  output logic orphan,
  output logic ready
);
  assign cand   = valid & sop;
  // Only mid-packet beats seen while idle are orphans; they are swallowed.
  assign orphan = idle & valid & ~sop;
  // Gated by reset so ready is 0 while reset is held, even in IDLE.
  assign ready  = rst_n & (orphan | (granted & ready_tx));
endmodule

module swm_tx_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BURST = 64
) (
  input  logic                    clk_in_clk,
  input  logic                    reset_in_rst,
  input  logic [NUM_SRC*32-1:0]   avalonst_sink_data,
  input  logic [NUM_SRC-1:0]      avalonst_sink_valid,
  input  logic [NUM_SRC-1:0]      avalonst_sink_startofpacket,
  input  logic [NUM_SRC-1:0]      avalonst_sink_endofpacket,
  output logic [NUM_SRC-1:0]      avalonst_sink_ready,
  output logic [255:0]            data_tx,
  output logic                    valid_tx,
  output logic                    start_of_burst_tx,
  output logic                    end_of_burst_tx,
  output logic [7:0]              sync_tx,
  input  logic                    ready_tx,
  output logic [15:0]             drop_count
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   grant, grant_nxt, rr, rr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [15:0]     drop_q, drop_nxt;

  logic [NUM_SRC-1:0][31:0] src_data;
  logic [NUM_SRC-1:0]       cand, orphan, gnt_oh;
  logic                     busy, win_found, g_valid, g_eop, xfer;
  logic [IW-1:0]            win_idx;
  logic [31:0]              g_data;
  logic [4:0]               n_orph;
  logic [16:0]              drop_sum;

  assign src_data = avalonst_sink_data;
  assign busy     = (state == BUSY);

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_SRC; i++)
      gnt_oh[i] = busy & (grant == IW'(i));
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    swm_tx_lane u_lane (
      .rst_n    (reset_in_rst),
      .idle     (~busy),
      .granted  (gnt_oh[i]),
      .ready_tx (ready_tx),
      .valid    (avalonst_sink_valid[i]),
      .sop      (avalonst_sink_startofpacket[i]),
      .cand     (cand[i]),
      .orphan   (orphan[i]),
      .ready    (avalonst_sink_ready[i])
    );
  end

  // Rotating priority: first SOP requester at or after rr, wrapping.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!win_found && cand[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  assign g_valid = avalonst_sink_valid[grant];
  assign g_eop   = avalonst_sink_endofpacket[grant];
  assign g_data  = src_data[grant];

  assign valid_tx          = busy & g_valid;
  assign data_tx           = busy ? {224'd0, g_data} : 256'd0;
  assign sync_tx           = busy ? 8'(grant) : 8'd0;
  assign start_of_burst_tx = valid_tx & (cnt == '0);
  assign end_of_burst_tx   = valid_tx & (g_eop | (cnt == CNT_LAST));
  assign xfer              = valid_tx & ready_tx;
  assign drop_count        = drop_q;

  always_comb begin
    n_orph = '0;
    for (int i = 0; i < NUM_SRC; i++)
      n_orph = n_orph + 5'(orphan[i]);
    drop_sum = {1'b0, drop_q} + 17'(n_orph);
    drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt = win_idx;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          // Counter wraps at every burst end, forced split or EOP alike.
          cnt_nxt = end_of_burst_tx ? '0 : cnt + 1'b1;
          if (g_eop) begin
            rr_nxt    = (grant == IW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in_clk or negedge reset_in_rst) begin
    if (!reset_in_rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr     <= '0;
      cnt    <= '0;
      drop_q <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr     <= rr_nxt;
      cnt    <= cnt_nxt;
      drop_q <= drop_nxt;
    end
  end
endmodule

// File: doc/swm_tx_arbiter.md
Name: swm_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing the SerialLite3 TX burst interface between NUM_SRC Avalon-ST 32-bit sources.
- Places the granted source's 32-bit word in data_tx[31:0] and zero-fills the rest, mirroring the RX adapter's lane usage.
- Tags every beat with the source index on sync_tx so the far-end RX can demultiplex.
- Splits packets longer than MAX_BURST beats into multiple SerialLite3 bursts.

Parameters:
- NUM_SRC, 2, number of Avalon-ST sink requesters (2..8).
- MAX_BURST, 64, maximum beats per SerialLite3 burst (2..256).

Ports:
- clk_in_clk  in  1  single clock.
- reset_in_rst  in  1  asynchronous, active-low reset.
- avalonst_sink_data  in  NUM_SRC*32  source i at bits [32i+31:32i].
- avalonst_sink_valid  in  NUM_SRC  per-source valid.
- avalonst_sink_startofpacket  in  NUM_SRC  per-source SOP.
- avalonst_sink_endofpacket  in  NUM_SRC  per-source EOP.
- avalonst_sink_ready  out  NUM_SRC  per-source ready.
- data_tx  out  256  [31:0] granted data, [255:32] = 0.
- valid_tx  out  1  beat valid.
- start_of_burst_tx  out  1  first beat of burst.
- end_of_burst_tx  out  1  last beat of burst.
- sync_tx  out  8  granted source index, zero-extended.
- ready_tx  in  1  SerialLite3 TX ready.
- drop_count  out  16  saturating count of discarded orphan beats.

Behaviour:
- Reset (reset_in_rst=0, asynchronous):
  - State = IDLE, rr pointer = 0, beat counter = 0, drop_count = 0.
  - All outputs 0; avalonst_sink_ready = 0; data_tx = 0.
- State IDLE:
  - Candidate set: sources with valid=1 and startofpacket=1.
  - Winner: first candidate at or after rr pointer, modulo NUM_SRC.
  - If a winner exists: latch grant index, beat counter = 0, go to BUSY next cycle. No beat is transferred in the IDLE cycle, so grant latency is 1 cycle.
  - Orphans (valid=1, startofpacket=0) in IDLE: ready=1 for that source; the beat is consumed and discarded; drop_count += 1 per orphan beat, saturating at 0xFFFF. Multiple orphans in one cycle count individually.
- State BUSY, grant g:
  - Pass-through: valid_tx = valid[g], data_tx[31:0] = data[g], sync_tx = g, avalonst_sink_ready[g] = ready_tx. All other ready = 0.
  - Beat transfers when valid[g] & ready_tx.
  - start_of_burst_tx = valid_tx & (beat counter == 0).
  - end_of_burst_tx = valid_tx & (eop[g] | beat counter == MAX_BURST-1).
  - On a transfer: if end_of_burst_tx, beat counter = 0; else beat counter += 1.
  - On a transfer with eop[g]=1: rr pointer = (g+1) mod NUM_SRC, go to IDLE.
  - A forced burst split (counter wrap without EOP) stays in BUSY with the same grant. The next beat asserts start_of_burst_tx again.
  - SOP=1 from g mid-packet is forwarded unmodified; no re-arbitration.
  - A 1-beat packet (SOP & EOP together) asserts start_of_burst_tx and end_of_burst_tx on the same beat.
- Stalls:
  - ready_tx=0: no state or counter change; outputs track the source combinationally.
  - valid[g]=0 in BUSY: valid_tx = 0, grant held.
- Reset asserted mid-packet aborts immediately; no end_of_burst_tx is emitted.
- Non-granted sources are never back-pressured into losing data; only the IDLE orphan case discards beats.

Test Plan:
- Single source 0 sends a 3-beat packet with ready_tx=1: 1 idle grant cycle, then 3 beats with sync_tx=0; SOP on beat 0, EOP on beat 2; data_tx[255:32]=0.
- Sources 0 and 1 both request continuously with 2-beat packets: grants alternate 0,1,0,1; each packet is preceded by one IDLE cycle.
- MAX_BURST=4, 10-beat packet: bursts of 4,4,2; start_of_burst_tx on beats 0,4,8; end_of_burst_tx on beats 3,7,9; grant held throughout.
- ready_tx toggled 1,0,0,1 mid-packet: beat count advances only on ready cycles; the source sees ready=0 while stalled; no data loss.
- Source 1 sends 3 beats without SOP while idle: 3 beats consumed, drop_count=3, valid_tx stays 0.
- Reset asserted on beat 2 of a 5-beat packet: all outputs 0 asynchronously. After release the next SOP is granted and counted from beat 0.
